reg_writeback: RTL and testbench
================================

REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered write entries.
REQ-002 Parameter ADDR_W, default 2, register address width, matching the 4-entry register bank.
REQ-003 Parameter DATA_W, default 8, register data width.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; state clears immediately when reset=0.
REQ-006 alu_valid  input  1  ALU result offered.
REQ-007 alu_ready  output  1  ALU offer accepted this cycle.
REQ-008 alu_addr  input  ADDR_W  ALU destination register.
REQ-009 alu_data  input  DATA_W  ALU result value.
REQ-010 mem_valid  input  1  load result offered.
REQ-011 mem_ready  output  1  load offer accepted this cycle.
REQ-012 mem_addr  input  ADDR_W  load destination register.
REQ-013 mem_data  input  DATA_W  load value.
REQ-014 hold  input  1  bank write freeze; no write is issued while 1.
REQ-015 EscReg  output  1  register-bank write enable.
REQ-016 write_addr  output  ADDR_W  register-bank write address.
REQ-017 write_data  output  DATA_W  register-bank write data.
REQ-018 pending  output  2**ADDR_W  bit i=1 while any buffered entry targets register i.
REQ-019 fifo_count  output  $clog2(DEPTH)+1  number of buffered entries.

Function
REQ-020 The block SHALL buffer write requests in a DEPTH-entry FIFO and drive them to the register bank in acceptance order.
REQ-021 The block SHALL accept at most one request per cycle; a transfer occurs on a rising edge where valid=1 and ready=1.
REQ-022 mem_ready SHALL be 1 when fifo_count<DEPTH; alu_ready SHALL be 1 when fifo_count<DEPTH and mem_valid=0 (fixed load priority).
REQ-023 When full, both ready outputs SHALL be 0 even if a pop occurs in the same cycle (no push-through on full).
REQ-024 EscReg SHALL equal (fifo_count!=0) and hold=0; write_addr/write_data SHALL present the FIFO head when EscReg=1 and 0 otherwise.
REQ-025 The head entry SHALL be popped on each rising edge where EscReg=1; the bank captures it on that same edge.
REQ-026 Minimum latency: entry accepted at edge k SHALL be presented with EscReg=1 during the cycle after edge k and written at edge k+1; there is no same-cycle bypass.
REQ-027 Simultaneous push and pop SHALL leave fifo_count unchanged and preserve ordering.
REQ-028 Read/write pointers SHALL wrap modulo DEPTH without loss or duplication.
REQ-029 Per-register pending counters (width $clog2(DEPTH)+1) SHALL increment on push to that register and decrement on pop from it; push and pop to the same register in one cycle SHALL leave it unchanged.
REQ-030 pending[i] SHALL equal (counter i != 0); multiple entries to one register SHALL all be written, in order, with no collapsing.
REQ-031 Requests offered while ready=0 SHALL be ignored; the producer holds them.

Reset
REQ-032 While reset=0: FIFO empty, pointers 0, fifo_count=0, pending=0, EscReg=0, write_addr=0, write_data=0, alu_ready=0, mem_ready=0.
REQ-033 Reset asserted mid-operation SHALL discard all buffered entries without issuing further writes.
REQ-034 After reset deasserts, both ready outputs SHALL be 1 (subject to REQ-022) from the first rising edge.

Structure
REQ-035 DEPTH, ADDR_W, DATA_W defaults and the entry record (addr, data) SHALL live in a shared package reg_pkg.
REQ-036 The FIFO storage and pointers SHALL be one sub-module, wb_fifo; arbitration and pending counters stay in reg_writeback.

Verification
REQ-037 Single ALU write: alu_valid=1, alu_addr=2, alu_data=8'hA5 for one cycle, hold=0 -> next cycle EscReg=1, write_addr=2, write_data=8'hA5, pending=4'b0100; following cycle EscReg=0, pending=0.
REQ-038 Priority: alu_valid=mem_valid=1 (alu 1/8'h11, mem 3/8'h33) same cycle -> mem_ready=1, alu_ready=0; writes issued 3/8'h33 then 1/8'h11.
REQ-039 Full: hold=1, push 5 mem writes 0..3,0 -> after four fifo_count=4, mem_ready=0, fifth held; release hold -> five writes in order 0,1,2,3,0, no loss.
REQ-040 Pending count: hold=1, push reg 1 twice (8'h01, 8'h02) -> pending[1]=1 until both written after hold=0; bank sees 8'h01 then 8'h02.
REQ-041 Wrap-around: stream 12 back-to-back ALU writes with hold toggling every 3 cycles -> output sequence equals input sequence exactly.
REQ-042 Reset mid-operation: 3 entries buffered, reset=0 for one cycle -> EscReg=0, fifo_count=0, pending=0 immediately; no stale write after reset=1.

Source files
------------

// File: rtl/reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_pkg
//  Description : Shared defaults and the write-entry record for the register
//                writeback path.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_pkg;

   localparam int c_DEPTH  = 4;
   localparam int c_ADDR_W = 2;
   localparam int c_DATA_W = 8;

   // One buffered register-bank write
   typedef struct packed {
      logic [c_ADDR_W-1:0] addr;
      logic [c_DATA_W-1:0] data;
   } wb_entry_t;

   // Width of an occupancy counter able to hold 0..depth
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/reg_writeback_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_writeback_if
//  Description : Producer handshakes (ALU, load) and register-bank write port
//                of the writeback block.
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_writeback_if
   import reg_pkg::*;
#(
   parameter int DEPTH  = c_DEPTH,
   parameter int ADDR_W = c_ADDR_W,
   parameter int DATA_W = c_DATA_W
) ();

   localparam int CNT_W = cnt_w(DEPTH);

   logic                 alu_valid;
   logic                 alu_ready;
   logic [ADDR_W-1:0]    alu_addr;
   logic [DATA_W-1:0]    alu_data;
   logic                 mem_valid;
   logic                 mem_ready;
   logic [ADDR_W-1:0]    mem_addr;
   logic [DATA_W-1:0]    mem_data;
   logic                 hold;
   logic                 EscReg;
   logic [ADDR_W-1:0]    write_addr;
   logic [DATA_W-1:0]    write_data;
   logic [2**ADDR_W-1:0] pending;
   logic [CNT_W-1:0]     fifo_count;

   // Environment side: producers, hold control and bank observer
   modport master (
      output alu_valid, alu_addr, alu_data,
      output mem_valid, mem_addr, mem_data,
      output hold,
      input  alu_ready, mem_ready,
      input  EscReg, write_addr, write_data, pending, fifo_count
   );

   // Writeback block side
   modport slave (
      input  alu_valid, alu_addr, alu_data,
      input  mem_valid, mem_addr, mem_data,
      input  hold,
      output alu_ready, mem_ready,
      output EscReg, write_addr, write_data, pending, fifo_count
   );

endinterface
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_fifo
//  Description : DEPTH-entry FIFO with wrapping pointers and occupancy count.
//                Caller guarantees no push when full and no pop when empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
   import reg_pkg::*;
#(
   parameter int DEPTH = c_DEPTH,
   parameter int WIDTH = c_ADDR_W + c_DATA_W
) (
   input  wire logic                      clk,
   input  wire logic                      reset,
   input  wire logic                      i_push,
   input  wire logic [WIDTH-1:0]          i_wdata,
   input  wire logic                      i_pop,
   output logic      [WIDTH-1:0]          o_rdata,
   output logic      [cnt_w(DEPTH)-1:0]   o_count
);

   localparam int CNT_W = cnt_w(DEPTH);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic [PTR_W-1:0] w_wr_nxt;
   logic [PTR_W-1:0] w_rd_nxt;

   // Pointers wrap explicitly so non-power-of-two depths also work
   assign w_wr_nxt = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
   assign w_rd_nxt = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);

   // Storage write; contents need no reset since the count gates visibility
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_wdata;
   end

   // Pointer and occupancy update; push+pop together leaves count unchanged
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= w_wr_nxt;
         if (i_pop)  r_rd_ptr <= w_rd_nxt;
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/reg_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : reg_writeback
//  Description : Buffers ALU and load results and drains them in order to the
//                register bank. Loads win arbitration; per-register pending
//                counters flag registers with writes still in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_writeback
   import reg_pkg::*;
#(
   parameter int DEPTH  = c_DEPTH,
   parameter int ADDR_W = c_ADDR_W,
   parameter int DATA_W = c_DATA_W
) (
   input  wire logic       clk,
   input  wire logic       reset,
   reg_writeback_if.slave  bus
);

   localparam int CNT_W = cnt_w(DEPTH);
   localparam int NREG  = 2 ** ADDR_W;
   localparam int ENT_W = ADDR_W + DATA_W;

   logic [CNT_W-1:0]  w_count;
   logic              w_full;
   logic              w_mem_rdy;
   logic              w_alu_rdy;
   logic              w_mem_acc;
   logic              w_alu_acc;
   logic              w_push;
   logic [ADDR_W-1:0] w_push_addr;
   logic [DATA_W-1:0] w_push_data;
   logic [ENT_W-1:0]  w_head;
   logic [ADDR_W-1:0] w_head_addr;
   logic [DATA_W-1:0] w_head_data;
   logic              w_wr_en;
   logic [NREG-1:0]   w_pend;

   // Readiness looks only at the current count: a pop in the same cycle does
   // not free a slot for a push while full. Gated by reset so nothing is
   // accepted while the block is held in reset.
   assign w_full    = (w_count == CNT_W'(DEPTH));
   assign w_mem_rdy = reset & ~w_full;
   assign w_alu_rdy = w_mem_rdy & ~bus.mem_valid;

   assign w_mem_acc   = bus.mem_valid & w_mem_rdy;
   assign w_alu_acc   = bus.alu_valid & w_alu_rdy;
   assign w_push      = w_mem_acc | w_alu_acc;
   assign w_push_addr = w_mem_acc ? bus.mem_addr : bus.alu_addr;
   assign w_push_data = w_mem_acc ? bus.mem_data : bus.alu_data;

   // A write is issued whenever something is buffered and the bank is not frozen
   assign w_wr_en = (w_count != '0) & ~bus.hold;

   wb_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENT_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_wdata ({w_push_addr, w_push_data}),
      .i_pop   (w_wr_en),
      .o_rdata (w_head),
      .o_count (w_count)
   );

   assign w_head_addr = w_head[ENT_W-1 -: ADDR_W];
   assign w_head_data = w_head[DATA_W-1:0];

   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
         logic [CNT_W-1:0] r_pcnt;
         logic             w_inc;
         logic             w_dec;

         assign w_inc = w_push  & (w_push_addr == ADDR_W'(gi));
         assign w_dec = w_wr_en & (w_head_addr == ADDR_W'(gi));

         // Count in-flight writes to this register; simultaneous inc/dec cancel
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               r_pcnt <= '0;
            end else if (w_inc && !w_dec) begin
               r_pcnt <= r_pcnt + CNT_W'(1);
            end else if (w_dec && !w_inc) begin
               r_pcnt <= r_pcnt - CNT_W'(1);
            end
         end

         assign w_pend[gi] = (r_pcnt != '0);
      end
   endgenerate

   assign bus.mem_ready  = w_mem_rdy;
   assign bus.alu_ready  = w_alu_rdy;
   assign bus.EscReg     = w_wr_en;
   assign bus.write_addr = w_wr_en ? w_head_addr : '0;
   assign bus.write_data = w_wr_en ? w_head_data : '0;
   assign bus.pending    = w_pend;
   assign bus.fifo_count = w_count;

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_writeback
//  Description : Directed bench for reg_writeback with an ordered scoreboard of
//                expected bank writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_writeback;
   import reg_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   reg_writeback_if #(.DEPTH(c_DEPTH), .ADDR_W(c_ADDR_W), .DATA_W(c_DATA_W)) bus ();

   reg_writeback #(.DEPTH(c_DEPTH), .ADDR_W(c_ADDR_W), .DATA_W(c_DATA_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   wb_entry_t exp_q[$];
   int        n_cmp = 0;
   int        n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expect_wr(input logic [c_ADDR_W-1:0] a, input logic [c_DATA_W-1:0] d);
      wb_entry_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   // Monitor: every cycle presenting EscReg=1 is one bank write
   initial begin : monitor
      wb_entry_t e;
      forever begin
         @(negedge clk);
         if (reset && bus.EscReg === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_write: got addr %0h data %0h expected none at %0t",
                        bus.write_addr, bus.write_data, $time);
            end else begin
               e = exp_q.pop_front();
               chk("wr_addr", 32'(bus.write_addr), 32'(e.addr));
               chk("wr_data", 32'(bus.write_data), 32'(e.data));
            end
         end
      end
   end

   // Offer a load until accepted (called #1 after a rising edge)
   task automatic offer_mem(input logic [c_ADDR_W-1:0] a, input logic [c_DATA_W-1:0] d);
      logic got;
      got = 1'b0;
      bus.mem_addr  = a;
      bus.mem_data  = d;
      bus.mem_valid = 1'b1;
      expect_wr(a, d);
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         got = bus.mem_ready;
         @(posedge clk);
         if (got) break;
      end
      #1 bus.mem_valid = 1'b0;
      if (!got) begin
         n_cmp++;
         n_bad++;
         $display("FAIL mem_accept_timeout: got no accept expected accept at %0t", $time);
      end
   endtask

   // Offer an ALU result until accepted (called #1 after a rising edge)
   task automatic offer_alu(input logic [c_ADDR_W-1:0] a, input logic [c_DATA_W-1:0] d);
      logic got;
      got = 1'b0;
      bus.alu_addr  = a;
      bus.alu_data  = d;
      bus.alu_valid = 1'b1;
      expect_wr(a, d);
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         got = bus.alu_ready;
         @(posedge clk);
         if (got) break;
      end
      #1 bus.alu_valid = 1'b0;
      if (!got) begin
         n_cmp++;
         n_bad++;
         $display("FAIL alu_accept_timeout: got no accept expected accept at %0t", $time);
      end
   endtask

   // Wait for all expected writes to retire, then check idle state
   task automatic drain(input string name);
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #2;
         if (exp_q.size() == 0 && bus.fifo_count == 0) break;
      end
      chk({name, "_left"},    32'(exp_q.size()),   32'd0);
      chk({name, "_count"},   32'(bus.fifo_count), 32'd0);
      chk({name, "_pending"}, 32'(bus.pending),    32'd0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      bus.alu_valid = 1'b0;
      bus.alu_addr  = '0;
      bus.alu_data  = '0;
      bus.mem_valid = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_data  = '0;
      bus.hold      = 1'b0;

      // Reset state
      #2;
      chk("rst_esc",   32'(bus.EscReg),     32'd0);
      chk("rst_count", 32'(bus.fifo_count), 32'd0);
      chk("rst_pend",  32'(bus.pending),    32'd0);
      chk("rst_waddr", 32'(bus.write_addr), 32'd0);
      chk("rst_wdata", 32'(bus.write_data), 32'd0);
      chk("rst_mrdy",  32'(bus.mem_ready),  32'd0);
      chk("rst_ardy",  32'(bus.alu_ready),  32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("post_rst_mrdy", 32'(bus.mem_ready), 32'd1);
      chk("post_rst_ardy", 32'(bus.alu_ready), 32'd1);

      // Single ALU write with one-cycle latency
      @(posedge clk); #1;
      offer_alu(2'd2, 8'hA5);
      @(negedge clk);
      chk("single_esc",  32'(bus.EscReg),  32'd1);
      chk("single_pend", 32'(bus.pending), 32'b0100);
      @(negedge clk);
      chk("single_esc_after",  32'(bus.EscReg),  32'd0);
      chk("single_pend_after", 32'(bus.pending), 32'd0);
      drain("single");

      // Load has priority over ALU
      @(posedge clk); #1;
      bus.mem_valid = 1'b1; bus.mem_addr = 2'd3; bus.mem_data = 8'h33;
      bus.alu_valid = 1'b1; bus.alu_addr = 2'd1; bus.alu_data = 8'h11;
      expect_wr(2'd3, 8'h33);
      expect_wr(2'd1, 8'h11);
      @(negedge clk);
      chk("prio_mrdy", 32'(bus.mem_ready), 32'd1);
      chk("prio_ardy", 32'(bus.alu_ready), 32'd0);
      @(posedge clk); #1;
      bus.mem_valid = 1'b0;
      @(negedge clk);
      chk("prio_ardy2", 32'(bus.alu_ready), 32'd1);
      @(posedge clk); #1;
      bus.alu_valid = 1'b0;
      drain("prio");

      // Full FIFO: fifth load held until hold releases
      @(posedge clk); #1;
      bus.hold = 1'b1;
      for (int i = 0; i < 4; i++) offer_mem(2'(i), 8'hC0 + 8'(i));
      @(negedge clk);
      chk("full_count", 32'(bus.fifo_count), 32'd4);
      chk("full_mrdy",  32'(bus.mem_ready),  32'd0);
      chk("full_ardy",  32'(bus.alu_ready),  32'd0);
      chk("full_pend",  32'(bus.pending),    32'b1111);
      @(posedge clk); #1;
      fork
         offer_mem(2'd0, 8'hC4);
         begin
            repeat (3) begin
               @(negedge clk);
               chk("full_held_count", 32'(bus.fifo_count), 32'd4);
               chk("full_held_mrdy",  32'(bus.mem_ready),  32'd0);
            end
            @(posedge clk); #1;
            bus.hold = 1'b0;
            @(negedge clk);
            chk("full_pop_no_push", 32'(bus.mem_ready), 32'd0);
         end
      join
      drain("full");

      // Two writes to one register stay distinct and ordered
      @(posedge clk); #1;
      bus.hold = 1'b1;
      offer_alu(2'd1, 8'h01);
      offer_alu(2'd1, 8'h02);
      @(negedge clk);
      chk("pcnt_pend",  32'(bus.pending),    32'b0010);
      chk("pcnt_count", 32'(bus.fifo_count), 32'd2);
      @(posedge clk); #1;
      bus.hold = 1'b0;
      @(negedge clk);
      chk("pcnt_pend_w1", 32'(bus.pending), 32'b0010);
      @(negedge clk);
      chk("pcnt_pend_w2", 32'(bus.pending), 32'b0010);
      @(negedge clk);
      chk("pcnt_pend_done", 32'(bus.pending), 32'd0);
      drain("pcnt");

      // Wrap-around stream with hold toggling every 3 cycles
      @(posedge clk); #1;
      fork
         for (int i = 0; i < 12; i++) offer_alu(2'(i % 4), 8'h40 + 8'(i));
         begin
            for (int c = 0; c < 36; c++) begin
               @(posedge clk); #1;
               if (c % 3 == 2) bus.hold = ~bus.hold;
            end
            bus.hold = 1'b0;
         end
      join
      drain("wrap");

      // Reset mid-operation discards buffered entries
      @(posedge clk); #1;
      bus.hold = 1'b1;
      offer_alu(2'd0, 8'h70);
      offer_alu(2'd1, 8'h71);
      offer_alu(2'd2, 8'h72);
      @(negedge clk);
      chk("mrst_count_before", 32'(bus.fifo_count), 32'd3);
      chk("mrst_pend_before",  32'(bus.pending),    32'b0111);
      #2;
      reset = 1'b0;
      #1;
      exp_q.delete();
      chk("mrst_esc",   32'(bus.EscReg),     32'd0);
      chk("mrst_count", 32'(bus.fifo_count), 32'd0);
      chk("mrst_pend",  32'(bus.pending),    32'd0);
      chk("mrst_mrdy",  32'(bus.mem_ready),  32'd0);
      bus.hold = 1'b0;
      @(negedge clk);
      chk("mrst_esc_nohold", 32'(bus.EscReg), 32'd0);
      #2;
      reset = 1'b1;
      repeat (6) @(posedge clk);
      #2;
      chk("mrst_count_after", 32'(bus.fifo_count), 32'd0);
      chk("mrst_mrdy_after",  32'(bus.mem_ready),  32'd1);

      // Ordering still intact after reset
      @(posedge clk); #1;
      offer_mem(2'd3, 8'h9C);
      drain("after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
